// File: rtl/inst_loader_pkg.sv
// Shared constants and loader state encoding for the instruction-memory program writer.
package inst_loader_pkg;

   localparam int INST_ADDR_SIZE = 64;
   localparam int IR_WIDTH       = 32;
   localparam int ADDR_W         = $clog2(INST_ADDR_SIZE);

   typedef enum logic [1:0] {
      LDR_IDLE = 2'd0,
      LDR_LOAD = 2'd1,
      LDR_DONE = 2'd2,
      LDR_ERR  = 2'd3
   } ldr_state_e;

endpackage

// File: rtl/inst_loader_packer.sv
// Big-endian 8-to-32 word assembly; flags a finished word in the same cycle as its closing byte.
module word_packer
   import inst_loader_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear_i,
   input  logic                accept_i,
   input  logic [7:0]          byte_i,
   input  logic                last_i,
   output logic                word_valid_o,
   output logic                short_o,
   output logic [IR_WIDTH-1:0] word_o
);

   logic [1:0]          idx_q, idx_d;
   logic [IR_WIDTH-1:0] acc_q, acc_d;

   always_comb begin
      // Bytes below the current index stay zero, which gives zero-padding for free.
      case (idx_q)
         2'd0:    word_o = {byte_i, 24'd0};
         2'd1:    word_o = {acc_q[31:24], byte_i, 16'd0};
         2'd2:    word_o = {acc_q[31:16], byte_i, 8'd0};
         default: word_o = {acc_q[31:8], byte_i};
      endcase
      word_valid_o = accept_i && ((idx_q == 2'd3) || last_i);
      short_o      = accept_i && last_i && (idx_q != 2'd3);

      idx_d = idx_q;
      acc_d = acc_q;
      if (clear_i) begin
         idx_d = 2'd0;
         acc_d = '0;
      end else if (accept_i) begin
         idx_d = word_valid_o ? 2'd0 : idx_q + 2'd1;
         acc_d = word_valid_o ? '0 : word_o;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q <= 2'd0;
         acc_q <= '0;
      end else begin
         idx_q <= idx_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/inst_loader.sv
// Loads a byte stream into instruction memory as consecutive words, then raises lock to let the datapath run.
module inst_loader
   import inst_loader_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                byte_valid,
   input  logic [7:0]          byte_data,
   input  logic                byte_last,
   output logic                byte_ready,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [IR_WIDTH-1:0] wr_data,
   output logic                lock,
   output logic                busy,
   output logic [ADDR_W:0]     word_count,
   output logic                err
);

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(INST_ADDR_SIZE);

   ldr_state_e          state_q, state_d;
   logic                byte_ready_q, byte_ready_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [IR_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                lock_q, lock_d;
   logic [ADDR_W:0]     word_count_q, word_count_d;
   logic                err_q, err_d;

   logic                accept, overflow, pack_accept;
   logic                word_valid, word_short;
   logic [IR_WIDTH-1:0] word;

   // A start in the same cycle as a handshake wins; the byte is treated as never accepted.
   assign accept      = (state_q == LDR_LOAD) && byte_ready_q && byte_valid && !start;
   assign overflow    = accept && (word_count_q == FULL_COUNT);
   assign pack_accept = accept && !overflow;

   word_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (start),
      .accept_i     (pack_accept),
      .byte_i       (byte_data),
      .last_i       (byte_last),
      .word_valid_o (word_valid),
      .short_o      (word_short),
      .word_o       (word)
   );

   always_comb begin
      state_d      = state_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      word_count_d = word_count_q;
      err_d        = err_q;

      if (start) begin
         state_d      = LDR_LOAD;
         word_count_d = '0;
         err_d        = 1'b0;
      end else if (state_q == LDR_LOAD) begin
         if (overflow) begin
            err_d   = 1'b1;
            state_d = LDR_ERR;
         end else if (word_valid) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = word_count_q[ADDR_W-1:0];
            wr_data_d    = word;
            word_count_d = (word_count_q == FULL_COUNT) ? FULL_COUNT : word_count_q + 1'b1;
            if (byte_last) begin
               state_d = LDR_DONE;
               if (word_short)
                  err_d = 1'b1;
            end
         end
      end

      // Lock trails DONE entry by one cycle so it rises only after the final write strobe.
      lock_d       = (state_q == LDR_DONE) && (state_d == LDR_DONE);
      byte_ready_d = (state_d == LDR_LOAD) && !wr_en_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= LDR_IDLE;
         byte_ready_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         lock_q       <= 1'b0;
         word_count_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_ready_q <= byte_ready_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         lock_q       <= lock_d;
         word_count_q <= word_count_d;
         err_q        <= err_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign lock       = lock_q;
   assign busy       = (state_q == LDR_LOAD);
   assign word_count = word_count_q;
   assign err        = err_q;

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
Program writer for the processor's instruction memory, on the opposite side of the fetch path.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Drives the instruction-memory write port with consecutive word addresses.
- Raises `lock`, the datapath run enable, once a complete program is loaded.
- The datapath fetches only while `lock` is high, so the loader owns the load-then-run sequencing.

Parameters:
- INST_ADDR_SIZE, 64, instruction memory depth in 32-bit words (matches the PC[7:0]>>2 fetch index).
- ADDR_W, 6, word address width, equal to log2(INST_ADDR_SIZE).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new load at word 0.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  program byte; first byte of each word goes to bits [31:24].
- byte_last  in  1  qualifies byte_valid; marks the final byte of the program.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_W  word address for the write.
- wr_data  out  32  instruction word for the write.
- lock  out  1  datapath run enable.
- busy  out  1  high in LOAD.
- word_count  out  ADDR_W+1  number of words written by the current or last load.
- err  out  1  sticky error; cleared by start or reset.

Behaviour:
- Reset (rst_n low at posedge):
  - State goes to IDLE.
  - lock, busy, byte_ready, wr_en, err are 0.
  - wr_addr, wr_data, word_count are 0.
  - Byte index and shift register are cleared.
  - Reset mid-load abandons the partial word with no write.
- Handshake:
  - A byte is accepted when byte_valid && byte_ready at posedge.
  - byte_ready = (state==LOAD) && !wr_en. This gives one bubble per word, so a write never collides with an accept.
  - byte_ready is registered.
- States:
  - IDLE: lock=0. start moves to LOAD.
  - LOAD: byte_ready per the rule above, busy=1, lock=0.
    - Each accepted byte shifts into the assembly register at byte index 0..3; the index then increments.
    - On the 4th byte (index 3), the next cycle has wr_en=1, wr_data=assembled word, wr_addr=word_count. word_count increments in that same cycle.
    - Index wraps to 0.
    - Write latency is 1 cycle after the accepting edge.
  - byte_last accepted at index 3: normal write, then DONE.
  - byte_last accepted at index <3: the remaining low bytes are zero-padded, the word is written the same way, err is set, then DONE.
  - An accepted byte that would start word INST_ADDR_SIZE (word_count==INST_ADDR_SIZE, index 0):
    - The byte is dropped and there is no write.
    - err=1 and the state moves to ERR.
  - DONE:
    - lock=1 from the cycle after the final write onward.
    - If err is set by zero-padding, lock is still 1.
    - byte_ready=0.
    - start: lock=0 in the next cycle, word_count=0, err=0, then LOAD.
  - ERR: lock=0, byte_ready=0. Only start (to LOAD, with err cleared) or reset leaves.
- start while in LOAD:
  - Restarts at word 0.
  - Any partial word is discarded.
  - err is cleared.
  - A same-cycle byte accept is ignored.
- start while in IDLE/DONE/ERR with byte_valid high: no byte is accepted that cycle, because byte_ready is still 0.
- byte_valid without byte_ready: no effect. The source must hold its data.
- wr_en is a single-cycle pulse. wr_addr and wr_data hold their last values when wr_en=0.
- word_count saturates at INST_ADDR_SIZE.

Decomposition:
- Shared package/header (global_def.h):
  - INST_ADDR_SIZE and IR_WIDTH (32), reused rather than redefined.
  - The state encoding: LDR_IDLE=2'd0, LDR_LOAD=2'd1, LDR_DONE=2'd2, LDR_ERR=2'd3.
- One natural sub-module, word_packer:
  - Performs 8-to-32 big-endian assembly with byte index, zero-pad on last, and word_valid output.
  - The FSM in inst_loader handles addressing, lock and errors.

Test Plan:
- Reset, start, then bytes 0x08,0x12,0x00,0x00,0x08,0x34,0x00,0x00 (last on byte 8) -> two writes:
  - wr_addr 0 data 0x08120000.
  - wr_addr 1 data 0x08340000.
  - Each write is 1 cycle after its 4th accept.
  - lock=1 the cycle after the 2nd write; word_count=2; err=0.
- Random byte_valid gaps with the same stream -> identical writes.
  - byte_ready is low in each write cycle.
  - No byte is lost or duplicated.
- Start, then 5 bytes 0xAA,0xBB,0xCC,0xDD,0xEE (last on 5th) -> writes:
  - 0xAABBCCDD @0.
  - 0xEE000000 @1.
  - err=1, lock=1.
- Load 64 full words, then one more byte -> 64 writes at addr 0..63, then no write, err=1, state ERR, lock=0.
  - Then start and one 4-byte word -> write @0, err cleared.
- rst_n low after 2 bytes of the 2nd word, then start and a new 4-byte program -> no write of the partial word, new write @0, lock=0 until done.
- In DONE with lock=1, pulse start -> lock=0 the next cycle, busy=1, word_count=0.
